pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised successor of the 4-bit ripple adder: WIDTH-bit adder/subtractor built from CHUNK-bit ripple slices.
//  Each slice is a register stage, so the carry chain is cut every CHUNK bits.
//  Streaming valid/ready interface with backpressure; sits in datapaths that need wide add/sub at high clock rate.
// PARAMETERS
//  WIDTH   16  operand/result width in bits
//  CHUNK   4   bits per ripple slice; STAGES = WIDTH/CHUNK pipeline stages (WIDTH % CHUNK != 0 -> elaboration error)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A (two's complement or unsigned)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin ; 1: a-b-cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      add: carry-out; sub: NOT borrow (1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all stage valid bits 0, all data regs 0; out_valid=0, sum=0, cout=0, ovf=0.
//  - Arithmetic: sub=1 -> slice 0 adds a + ~b with carry-in = ~cin; sub=0 -> a + b with carry-in = cin.
//  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1.
//  - Higher operand chunks travel in skew registers; lower result chunks travel in de-skew registers.
//  - Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, when out_ready is held at 1.
//  - Throughput: one beat per cycle when out_ready=1.
//  - Flow control: global advance = !out_valid | out_ready.
//    - in_ready = advance.
//    - All stages shift only on advance; otherwise every stage register holds.
//  - A bubble (in_valid=0 on advance) propagates as a valid=0 stage; bubbles are never compressed.
//  - Stall: while out_valid=1 & out_ready=0, sum/cout/ovf remain stable and in_ready=0.
//  - Ordering: results emerge in acceptance order; no loss, no duplication.
//  - Boundaries:
//    - carry out of bit WIDTH-1 -> cout; 0xFFFF+1 wraps to 0.
//    - sub with a<b (unsigned) -> cout=0.
//    - STAGES=1 is a registered single ripple adder.
//  - Reset mid-operation: in-flight beats are discarded, out_valid drops immediately (async).
//    - The first beat accepted after release computes correctly.
//  - ovf is valid for both add and sub.
// STRUCTURE
//  - Shared package adder_pkg:
//    - function/localparam computing STAGES.
//    - typedef for the stage record {valid, carry, a_hi, b_hi, sum_lo}.
//  - Sub-module adder_chunk (parameter CHUNK): purely combinational CHUNK-bit ripple of full adders.
//    - Ports a, b, cin, sum, cout, c_msb_in (carry into top bit, used for ovf).
//  - Top: generate loop of STAGES adder_chunk instances plus stage registers and the advance logic.
// TESTING (WIDTH=16, CHUNK=4 unless noted; golden model = behavioural a±b±cin)
//  1. a=0xFFFF b=0x0001 cin=0 sub=0, out_ready=1 -> after 4 cycles sum=0x0000 cout=1 ovf=0.
//  2. a=0x7FFF b=0x0001 cin=0 sub=0 -> sum=0x8000 cout=0 ovf=1.
//     a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF cout=1 ovf=1.
//  3. a=0x0003 b=0x0005 cin=1 sub=1 -> sum=0xFFFD cout=0 ovf=0.
//  4. Stream 64 random beats; in_valid and out_ready randomly toggled ->
//     - results in order, match model, no drops or duplicates.
//     - outputs stable while stalled.
//  5. rst_n pulled low at a mid-cycle point with 3 beats in flight -> out_valid=0 at once, in_ready=1 after release.
//     - next beat 0x1234+0x1111 -> 0x2345 after 4 cycles.
//  6. WIDTH=8 CHUNK=8 and WIDTH=8 CHUNK=2: exhaustive a,b,cin,sub (2^18 beats) vs model.
//     - latency checked as 1 and 4 respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage count and
// the per-stage control record that travels alongside the operand data.
package adder_pkg;

    // Number of register stages needed to cover WIDTH bits in CHUNK-bit slices.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Control part of a stage record. The width-dependent fields (the still
    // unprocessed high operand chunks and the finished low result chunks)
    // live in parametrised arrays in the top, next to this record.
    typedef struct packed {
        logic valid;   // beat present in this stage (0 = bubble)
        logic carry;   // carry out of this stage's slice, feeds the next slice
        logic c_msb;   // carry into the top bit of this slice, used for ovf
    } stage_ctrl_t;

endpackage

// File: rtl/adder_chunk.sv
// Purely combinational CHUNK-bit ripple-carry adder slice. Also exposes the
// carry into its top bit so the final slice can derive signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    // Ripple the carry bit by bit through CHUNK full adders.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit adder/subtractor pipelined as STAGES = WIDTH/CHUNK ripple slices.
// Stage k adds chunk k using the carry registered by stage k-1. Operands are
// carried forward (skewed) until their chunk is consumed; finished result
// chunks are carried forward (de-skewed) until the last stage. One global
// advance signal moves every stage at once, so bubbles are kept in place.
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
    end

    stage_ctrl_t      ctrl_q  [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];

    logic [CHUNK-1:0] chunk_a    [STAGES];
    logic [CHUNK-1:0] chunk_b    [STAGES];
    logic             chunk_cin  [STAGES];
    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];
    logic [WIDTH-1:0] sum_next   [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is a + ~b + ~cin, so borrow-in becomes an inverted carry-in
    // and cout naturally reads as "no borrow".
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;

    // The whole pipe moves together whenever the output slot is free or drained.
    assign advance  = !ctrl_q[STAGES-1].valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign chunk_a[k]   = a[CHUNK-1:0];
            assign chunk_b[k]   = b_eff[CHUNK-1:0];
            assign chunk_cin[k] = cin_eff;
            assign sum_next[k]  = WIDTH'(chunk_sum[k]);
        end else begin : g_rest
            // Bits above the chunks finished so far are still zero in sum_q,
            // so the new chunk can simply be OR-ed into place.
            assign chunk_a[k]   = a_q[k-1][k*CHUNK +: CHUNK];
            assign chunk_b[k]   = b_q[k-1][k*CHUNK +: CHUNK];
            assign chunk_cin[k] = ctrl_q[k-1].carry;
            assign sum_next[k]  = sum_q[k-1] | (WIDTH'(chunk_sum[k]) << (k*CHUNK));
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (chunk_a[k]),
            .b        (chunk_b[k]),
            .cin      (chunk_cin[k]),
            .sum      (chunk_sum[k]),
            .cout     (chunk_cout[k]),
            .c_msb_in (chunk_cmsb[k])
        );
    end

    // Stage registers: clear everything on reset, shift all stages on advance,
    // otherwise hold so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                ctrl_q[i] <= '0;
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                sum_q[i]  <= '0;
            end
        end else if (advance) begin
            ctrl_q[0] <= '{valid: in_valid, carry: chunk_cout[0], c_msb: chunk_cmsb[0]};
            a_q[0]    <= a;
            b_q[0]    <= b_eff;
            sum_q[0]  <= sum_next[0];
            for (int i = 1; i < STAGES; i++) begin
                ctrl_q[i] <= '{valid: ctrl_q[i-1].valid, carry: chunk_cout[i], c_msb: chunk_cmsb[i]};
                a_q[i]    <= a_q[i-1];
                b_q[i]    <= b_q[i-1];
                sum_q[i]  <= sum_next[i];
            end
        end
    end

    assign out_valid = ctrl_q[STAGES-1].valid;
    assign sum       = sum_q[STAGES-1];
    assign cout      = ctrl_q[STAGES-1].carry;
    assign ovf       = ctrl_q[STAGES-1].carry ^ ctrl_q[STAGES-1].c_msb;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed table, reset mid-flight, random
// streaming with backpressure on a 16/4 instance, and corner plus random
// sweeps on 8/8 and 8/2 instances, all against an arithmetic reference.
module tb_pipelined_add_sub;

    localparam int W      = 16;
    localparam int C      = 4;
    localparam int STAGES = W / C;

    logic          clk;
    logic          rst_n;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;

    logic          iv8, cin8, sub8;
    logic [7:0]    a8, b8;
    logic          irA, ovA, cA, fA, irB, ovB, cB, fB;
    logic [7:0]    sA, sB;

    int compared   = 0;
    int mismatched = 0;
    int cycleNum   = 0;
    int acceptCnt  = 0;
    int popCnt     = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acceptCycle;
        bit           chkLat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    typedef struct {
        logic       iv;
        logic [7:0] a, b;
        logic       cin, sub;
    } hist_t;

    exp_t  sbq[$];
    hist_t hist[$];
    vec_t  vecs[12];
    bit    latencyMode = 0;
    bit    prevStall   = 0;
    logic [W-1:0] prevSum;
    logic  prevCout, prevOvf;

    pipelined_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) dut8x8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(irA),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ovA),
        .out_ready(1'b1), .sum(sA), .cout(cA), .ovf(fA)
    );

    pipelined_add_sub #(.WIDTH(8), .CHUNK(2)) dut8x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(irB),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ovB),
        .out_ready(1'b1), .sum(sB), .cout(cB), .ovf(fB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: exact integer a+b+cin or a-b-cin.
    function automatic void refModel(input int w, input longint ua, input longint ub,
                                     input int ci, input int sb,
                                     output longint rs, output logic rc, output logic ro);
        longint m, h, sa, sbv, u, s;
        m   = longint'(1) << w;
        h   = m >> 1;
        sa  = (ua >= h) ? ua - m : ua;
        sbv = (ub >= h) ? ub - m : ub;
        if (sb == 0) begin
            u  = ua + ub + ci;
            s  = sa + sbv + ci;
            rc = (u >= m);
        end else begin
            u  = ua - ub - ci;
            s  = sa - sbv - ci;
            rc = (u >= 0);
        end
        rs = ((u % m) + m) % m;
        ro = (s < -h) || (s >= h);
    endfunction

    function automatic exp_t makeExp(input logic [W-1:0] ea, input logic [W-1:0] eb,
                                     input logic ec, input logic es);
        exp_t   e;
        longint rs;
        refModel(W, longint'(ea), longint'(eb), int'(ec), int'(es), rs, e.cout, e.ovf);
        e.sum         = rs[W-1:0];
        e.acceptCycle = 0;
        e.chkLat      = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle on the 16-bit DUT: drive at negedge, settle, score the
    // handshakes that the coming posedge will perform, then move on.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic icin, input logic isub, input logic ordy,
                                 input exp_t e);
        exp_t e0;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (prevStall) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_sum", sum, prevSum);
            checkOutput("stall_cout", cout, prevCout);
            checkOutput("stall_ovf", ovf, prevOvf);
        end
        if (out_valid && !out_ready)
            checkOutput("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got sum %0h, required no beat", sum);
            end else begin
                e0 = sbq.pop_front();
                popCnt++;
                checkOutput("sum", sum, e0.sum);
                checkOutput("cout", cout, e0.cout);
                checkOutput("ovf", ovf, e0.ovf);
                if (e0.chkLat)
                    checkOutput("latency", cycleNum - e0.acceptCycle, STAGES);
            end
        end
        if (iv && in_ready) begin
            e.acceptCycle = cycleNum;
            e.chkLat      = latencyMode;
            sbq.push_back(e);
            acceptCnt++;
        end
        prevStall = out_valid && !out_ready;
        prevSum   = sum;
        prevCout  = cout;
        prevOvf   = ovf;
        cycleNum++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = makeExp('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e);
    endtask

    // Check one of the 8-bit DUTs against the beat applied 'lag' cycles ago.
    task automatic checkSmall(input string tag, input int lag, input logic ov,
                              input logic [7:0] s, input logic c, input logic f);
        hist_t  h;
        logic   expValid, rc, ro;
        longint rs;
        expValid = 1'b0;
        if (hist.size() >= lag) begin
            h        = hist[hist.size() - lag];
            expValid = h.iv;
        end
        checkOutput({tag, "_valid"}, ov, expValid);
        if (expValid) begin
            refModel(8, longint'(h.a), longint'(h.b), int'(h.cin), int'(h.sub), rs, rc, ro);
            checkOutput({tag, "_sum"}, s, rs[7:0]);
            checkOutput({tag, "_cout"}, c, rc);
            checkOutput({tag, "_ovf"}, f, ro);
        end
    endtask

    task automatic applySmall(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                              input logic icin, input logic isub);
        hist_t h;
        iv8  = iv;
        a8   = ia;
        b8   = ib;
        cin8 = icin;
        sub8 = isub;
        #1;
        checkSmall("w8c8", 1, ovA, sA, cA, fA);
        checkSmall("w8c2", 4, ovB, sB, cB, fB);
        h = '{iv: iv, a: ia, b: ib, cin: icin, sub: isub};
        hist.push_back(h);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   guard, popStart, accStart;
        logic [7:0] corner [5];

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, streamed back to back with out_ready held high.
        latencyMode = 1;
        for (int i = 0; i < 12; i++) begin
            e = '{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf, acceptCycle: 0, chkLat: 1'b0};
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, e);
        end
        idle(STAGES + 2);
        checkOutput("table_drained", sbq.size(), 0);

        // Reset with beats in flight, then one beat after release.
        for (int i = 0; i < 4; i++) begin
            e = makeExp(16'h0100 + 16'(i), 16'h0001, 1'b0, 1'b0);
            applyStimulus(1'b1, 16'h0100 + 16'(i), 16'h0001, 1'b0, 1'b0, 1'b1, e);
        end
        in_valid = 1'b0;
        #2;
        checkOutput("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_sum", sum, 0);
        sbq.delete();
        prevStall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);
        checkOutput("post_reset_out_valid", out_valid, 0);
        @(negedge clk);
        e = '{sum: 16'h2345, cout: 1'b0, ovf: 1'b0, acceptCycle: 0, chkLat: 1'b0};
        applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, e);
        idle(STAGES + 2);
        checkOutput("post_reset_drained", sbq.size(), 0);

        // Random streaming with bubbles and backpressure.
        latencyMode = 0;
        accStart = acceptCnt;
        popStart = popCnt;
        guard = 0;
        while ((acceptCnt - accStart) < 64 && guard < 2000) begin
            logic [W-1:0] ra, rb;
            logic rc, rsub, riv, rrdy;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            rsub = 1'($urandom);
            riv  = ($urandom % 4) != 0;
            rrdy = ($urandom % 3) != 0;
            e = makeExp(ra, rb, rc, rsub);
            applyStimulus(riv, ra, rb, rc, rsub, rrdy, e);
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        idle(2);
        checkOutput("random_accepted", acceptCnt - accStart, 64);
        checkOutput("random_delivered", popCnt - popStart, 64);
        checkOutput("random_drained", sbq.size(), 0);

        // 8-bit instances: corner operands first, then random beats with bubbles.
        corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
        corner[3] = 8'h80; corner[4] = 8'hFF;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < 4; k++)
                    applySmall(1'b1, corner[i], corner[j], k[0], k[1]);
        for (int n = 0; n < 3000; n++)
            applySmall(($urandom % 8) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int n = 0; n < 5; n++)
            applySmall(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
